// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Optional macro BP_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred,
  input  logic [31:0] upd_pred_target,
`ifdef BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             mis_d;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup reads the pre-update table; a same-cycle write shows up next cycle.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? {target_q[if_idx], 2'b00} : 32'd0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // upd_valid is a single-cycle strobe with no ready: the predictor accepts every
  // resolution presented on a cycle where upd_valid=1 and never back-pressures EM.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_q[upd_idx] <= upd_target[31:2];
        end else begin
          ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target[31:2];
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  assign mis_d = (upd_pred != upd_taken) ||
                 (upd_pred && upd_taken && (upd_pred_target != upd_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      mispredict <= upd_valid && mis_d;
      if (upd_valid) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (upd_valid) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: driver pushes expectations tagged with a cycle,
// a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.IDX_W(4), .TAG_W(26)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred        (upd_pred),
    .upd_pred_target (upd_pred_target),
`ifdef BP_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  id;
    logic        chk_pred;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        chk_mis;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic        chk_stat;
    logic [31:0] exp_br;
    logic [31:0] exp_mp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   next_id = 0;

  function automatic exp_t blank(input int at);
    exp_t e;
    e = '0;
    e.cyc = 16'(at);
    e.id  = 8'(next_id);
    return e;
  endfunction

  // driver tasks
  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    exp_t e;
    if_pc = pc;
    e = blank(cyc);
    e.chk_pred = 1'b1; e.exp_taken = t; e.exp_target = tgt;
    exp_q.push_back(e);
    next_id++;
  endtask

  task automatic push_mis(input logic m, input logic [31:0] r, input int at);
    exp_t e;
    e = blank(cyc + at);
    e.chk_mis = 1'b1; e.exp_mis = m; e.exp_redir = r;
    exp_q.push_back(e);
    next_id++;
  endtask

  task automatic push_stat(input logic [31:0] br, input logic [31:0] mp);
    exp_t e;
    e = blank(cyc);
    e.chk_stat = 1'b1; e.exp_br = br; e.exp_mp = mp;
    exp_q.push_back(e);
    next_id++;
  endtask

  task automatic upd_raw(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic p, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred = p; upd_pred_target = ptgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic p, input logic [31:0] ptgt,
                     input logic m_exp, input logic [31:0] r_exp);
    upd_raw(pc, t, tgt, p, ptgt);
    push_mis(m_exp, r_exp, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  // scoreboard monitor
  exp_t mon_e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= 16'(cyc)) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc != 16'(cyc)) begin
        n_vec++; n_err++;
        $display("FAIL stale_chk%0d: due cycle %0d, seen at cycle %0d", mon_e.id, mon_e.cyc, cyc);
      end else begin
        if (mon_e.chk_pred) begin
          n_vec++;
          if (pred_taken !== mon_e.exp_taken || pred_target !== mon_e.exp_target) begin
            n_err++;
            $display("FAIL lookup_chk%0d pc=%h: got taken=%b target=%h, want taken=%b target=%h",
                     mon_e.id, if_pc, pred_taken, pred_target, mon_e.exp_taken, mon_e.exp_target);
          end
        end
        if (mon_e.chk_mis) begin
          n_vec++;
          if (mispredict !== mon_e.exp_mis || redirect_pc !== mon_e.exp_redir) begin
            n_err++;
            $display("FAIL redirect_chk%0d: got mispredict=%b redirect=%h, want mispredict=%b redirect=%h",
                     mon_e.id, mispredict, redirect_pc, mon_e.exp_mis, mon_e.exp_redir);
          end
        end
`ifdef BP_STATS_EN
        if (mon_e.chk_stat) begin
          n_vec++;
          if (stat_branches !== mon_e.exp_br || stat_mispredicts !== mon_e.exp_mp) begin
            n_err++;
            $display("FAIL stats_chk%0d: got branches=%0d mispredicts=%0d, want %0d/%0d",
                     mon_e.id, stat_branches, stat_mispredicts, mon_e.exp_br, mon_e.exp_mp);
          end
        end
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; if_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred = 1'b0; upd_pred_target = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    look(32'h40, 1'b0, 32'h0); push_mis(1'b0, 32'h0, 0); tick();
    // allocate 0x40 -> 0x100, predicted not-taken
    look(32'h40, 1'b0, 32'h0); upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100); tick();
    look(32'h40, 1'b1, 32'h100); tick();
    // ctr 10 -> 11 -> 11 -> 10 -> 01
    look(32'h40, 1'b1, 32'h100); upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100); tick();
    look(32'h40, 1'b1, 32'h100); upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100); tick();
    look(32'h40, 1'b1, 32'h100); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44); tick();
    look(32'h40, 1'b1, 32'h100); tick();
    look(32'h40, 1'b1, 32'h100); upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44); tick();
    look(32'h40, 1'b0, 32'h0); tick();
    look(32'h40, 1'b0, 32'h0); push_mis(1'b0, 32'h44, 0); tick();
    // 01 -> 00 -> 00 (floor) -> 01, still not taken
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44); tick();
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44); tick();
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100); tick();
    // 01 -> 10 with new target 0x200
    look(32'h40, 1'b0, 32'h0); upd(32'h40, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200); tick();
    // direction right, target wrong
    look(32'h40, 1'b1, 32'h200); upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200); tick();
    look(32'h40, 1'b1, 32'h200); tick();
    // not-taken miss: redirect to pc+4, no allocation
    look(32'h80, 1'b0, 32'h0); upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h84); tick();
    look(32'h80, 1'b0, 32'h0); tick();
    // aliasing: 0x440 evicts 0x40 at index 0
    look(32'h44, 1'b0, 32'h0); upd(32'h440, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300); tick();
    look(32'h440, 1'b1, 32'h300); tick();
    // pc+4 wraps to zero
    look(32'h40, 1'b0, 32'h0); upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0); tick();
    look(32'hFFFF_FFFC, 1'b0, 32'h0); tick();
    // reset beats a concurrent update
    rst = 1'b1; upd_raw(32'h44, 1'b1, 32'h500, 1'b0, 32'h0); push_mis(1'b0, 32'h0, 1); tick();
    rst = 1'b0;
    look(32'h44, 1'b0, 32'h0); tick();
    look(32'h440, 1'b0, 32'h0); tick();
    // three updates, one mispredict
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100); tick();
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100); tick();
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100); tick();
    look(32'h40, 1'b1, 32'h100); tick();
`ifdef BP_STATS_EN
    push_stat(32'd3, 32'd1);
`endif
    tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++; n_err++;
      $display("FAIL unchecked_chk%0d: due cycle %0d never reached by monitor", mon_e.id, mon_e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
